// File: rtl/cdc_pkg.sv
// Shared types for the Aclk->Bclk word crossing.
// Holds the source FSM state encoding, synchronizer depth and counter type.
package cdc_pkg;

    // Source-side handshake FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DROP  = 2'd2,
        FAULT = 2'd3
    } src_state_t;

    // Depth of every level synchronizer in the crossing.
    localparam int SYNC_STAGES = 2;

    // Completed-transfer counter.
    localparam int XFER_CNT_W = 16;
    typedef logic [XFER_CNT_W-1:0] xfer_cnt_t;

endpackage : cdc_pkg

// File: rtl/cdc_word_source_sync_2ff.sv
// sync_2ff: generic level synchronizer (SYNC_STAGES flops) for one bit.
// Ports: Aclk (dest clock), reset (sync, active-high), d (async in), q (synced out).
module sync_2ff
    import cdc_pkg::*;
(
    input  logic Aclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge Aclk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule : sync_2ff

// File: rtl/cdc_word_source.sv
// cdc_word_source: Aclk-side word source with a 4-phase req/ack handshake.
// Ports: Aclk, reset (sync, active-high), enable, ack_b (async) in;
//        req_a, data_a[WIDTH], busy, words_sent[16], timeout_err out.
// Build option: CDC_SRC_LFSR_EN selects a Galois LFSR word sequence,
//               otherwise the sequence is a wrapping incrementer.
module cdc_word_source
    import cdc_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(8'h01),
    parameter logic [WIDTH-1:0] POLY    = WIDTH'(8'hB8),
    parameter int               TIMEOUT = 255
) (
    input  logic             Aclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ack_b,
    output logic             req_a,
    output logic [WIDTH-1:0] data_a,
    output logic             busy,
    output xfer_cnt_t        words_sent,
    output logic             timeout_err
);

    localparam int PCW = $clog2(TIMEOUT + 1);
    // Fault is taken on the cycle the count would reach TIMEOUT,
    // so a phase lasts at most TIMEOUT cycles.
    localparam logic [PCW-1:0] PH_LAST = PCW'(TIMEOUT - 1);

`ifdef CDC_SRC_LFSR_EN
    // An all-zero LFSR state would lock up.
    localparam logic [WIDTH-1:0] SEED_EFF =
        (SEED == '0) ? WIDTH'(1) : SEED;
`else
    localparam logic [WIDTH-1:0] SEED_EFF = SEED;
`endif

    src_state_t       r_state;
    logic             r_req;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    xfer_cnt_t        r_words;
    logic             r_err;
    logic [PCW-1:0]   r_phase;

    logic             w_ack_s;
    logic [WIDTH-1:0] w_next;
    logic             w_ph_done;

    sync_2ff u_ack_sync (
        .Aclk  (Aclk),
        .reset (reset),
        .d     (ack_b),
        .q     (w_ack_s)
    );

`ifdef CDC_SRC_LFSR_EN
    always_comb begin
        w_next = r_data >> 1;
        if (r_data[0]) begin
            w_next = (r_data >> 1) ^ POLY;
        end
    end
`else
    logic w_unused_poly;
    assign w_unused_poly = ^POLY;

    always_comb begin
        w_next = r_data + WIDTH'(1);
    end
`endif

    assign w_ph_done = (r_phase == PH_LAST);

    always_ff @(posedge Aclk) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_data  <= SEED_EFF;
            r_busy  <= 1'b0;
            r_words <= '0;
            r_err   <= 1'b0;
            r_phase <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_phase <= '0;
                    // Wait for the previous ack to be released first.
                    if (enable && !w_ack_s) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                REQ: begin
                    if (w_ack_s) begin
                        r_state <= DROP;
                        r_req   <= 1'b0;
                        r_phase <= '0;
                    end else if (w_ph_done) begin
                        r_state <= FAULT;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_phase <= r_phase + PCW'(1);
                    end
                end
                DROP: begin
                    if (!w_ack_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_phase <= '0;
                        r_words <= r_words + XFER_CNT_W'(1);
                        // Only edge where the word may change.
                        r_data  <= w_next;
                    end else if (w_ph_done) begin
                        r_state <= FAULT;
                        r_err   <= 1'b1;
                    end else begin
                        r_phase <= r_phase + PCW'(1);
                    end
                end
                FAULT: begin
                    r_req   <= 1'b0;
                    r_err   <= 1'b1;
                    r_busy  <= 1'b1;
                    r_phase <= '0;
                end
                default: begin
                    r_state <= FAULT;
                    r_req   <= 1'b0;
                    r_err   <= 1'b1;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign req_a       = r_req;
    assign data_a      = r_data;
    assign busy        = r_busy;
    assign words_sent  = r_words;
    assign timeout_err = r_err;

endmodule : cdc_word_source

// File: tb/tb_cdc_word_source.sv
// Self-checking bench for cdc_word_source: random handshake delays,
// timeout, enable drop, reset mid-transfer and word sequence checks.
module tb_cdc_word_source;

    localparam int W1 = 8;
    localparam logic [W1-1:0] SEED1 = 8'h01;
    localparam logic [W1-1:0] POLY1 = 8'hB8;
    localparam int TO1 = 255;

`ifdef CDC_SRC_LFSR_EN
    localparam int W2 = 4;
    localparam logic [W2-1:0] SEED2 = 4'h1;
    localparam logic [W2-1:0] POLY2 = 4'h9;
    localparam int N2 = 16;
`else
    localparam int W2 = 8;
    localparam logic [W2-1:0] SEED2 = 8'hFE;
    localparam logic [W2-1:0] POLY2 = 8'hB8;
    localparam int N2 = 3;
`endif

    logic          Aclk = 1'b0;
    logic          reset = 1'b1;
    logic          en1 = 1'b0;
    logic          ack1 = 1'b0;
    logic          req1;
    logic [W1-1:0] data1;
    logic          busy1;
    logic [15:0]   ws1;
    logic          err1;

    logic          en2 = 1'b0;
    logic          ack2;
    logic          req2;
    logic [W2-1:0] data2;
    logic          busy2;
    logic [15:0]   ws2;
    logic          err2;

    int total = 0;
    int bad   = 0;

    always #18 Aclk = ~Aclk;

    cdc_word_source #(
        .WIDTH(W1), .SEED(SEED1), .POLY(POLY1), .TIMEOUT(TO1)
    ) u_dut (
        .Aclk(Aclk), .reset(reset), .enable(en1), .ack_b(ack1),
        .req_a(req1), .data_a(data1), .busy(busy1),
        .words_sent(ws1), .timeout_err(err1)
    );

    cdc_word_source #(
        .WIDTH(W2), .SEED(SEED2), .POLY(POLY2), .TIMEOUT(40)
    ) u_dut2 (
        .Aclk(Aclk), .reset(reset), .enable(en2), .ack_b(ack2),
        .req_a(req2), .data_a(data2), .busy(busy2),
        .words_sent(ws2), .timeout_err(err2)
    );

    // Simple Bclk-side stand-in for the second source: ack follows req.
    always @(posedge Aclk) begin
        if (reset) ack2 <= 1'b0;
        else       ack2 <= req2;
    end

    // Shadow of the internal two-flop ack synchronizers.
    logic a1s1 = 1'b0, a1s = 1'b0, a2s1 = 1'b0, a2s = 1'b0;
    always @(posedge Aclk) begin
        if (reset) begin
            a1s1 <= 1'b0; a1s <= 1'b0; a2s1 <= 1'b0; a2s <= 1'b0;
        end else begin
            a1s1 <= ack1; a1s <= a1s1; a2s1 <= ack2; a2s <= a2s1;
        end
    end

    // Word must not move while req or the synced ack is high.
    logic          p_rst = 1'b1;
    logic          p_req1 = 1'b0, p_ack1 = 1'b0;
    logic          p_req2 = 1'b0, p_ack2 = 1'b0;
    logic [W1-1:0] p_d1 = '0;
    logic [W2-1:0] p_d2 = '0;
    int            viol = 0;
    always @(negedge Aclk) begin
        if (!reset && !p_rst) begin
            if ((data1 !== p_d1) && (p_req1 || p_ack1)) viol <= viol + 1;
            if ((data2 !== p_d2) && (p_req2 || p_ack2)) viol <= viol + 1;
        end
        p_rst  <= reset;
        p_req1 <= req1; p_ack1 <= a1s; p_d1 <= data1;
        p_req2 <= req2; p_ack2 <= a2s; p_d2 <= data2;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next word, from the sequence rules in plain arithmetic.
    function automatic logic [W1-1:0] nxt1(input logic [W1-1:0] x);
`ifdef CDC_SRC_LFSR_EN
        int v;
        v = int'(x);
        if (v % 2 == 1) return W1'(v / 2) ^ POLY1;
        return W1'(v / 2);
`else
        return W1'((int'(x) + 1) % 256);
`endif
    endfunction

    logic [W1-1:0] exp_word = SEED1;
    int            exp_cnt  = 0;

    task automatic wait_req(input logic lvl, input string tag);
        int n;
        n = 0;
        while (req1 !== lvl && n < 200) begin
            @(negedge Aclk); n++;
        end
        chk(tag, req1, lvl);
    endtask

    // One full handshake on the first source, acting as Bclk responder.
    task automatic xfer(input int d_ack, input int d_rel, input bit drop_en);
        int n;
        wait_req(1'b1, "req_rise");
        chk("word", data1, exp_word);
        if (drop_en) begin
            @(negedge Aclk);
            en1 = 1'b0;
        end
        repeat (d_ack) @(negedge Aclk);
        chk("word_hold", data1, exp_word);
        ack1 = 1'b1;
        wait_req(1'b0, "req_fall");
        repeat (d_rel) @(negedge Aclk);
        ack1 = 1'b0;
        n = 0;
        while (ws1 !== 16'(exp_cnt + 1) && n < 200) begin
            @(negedge Aclk); n++;
        end
        exp_cnt++;
        exp_word = nxt1(exp_word);
        chk("count", ws1, exp_cnt);
        chk("next_word", data1, exp_word);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, dup;
        logic [W2-1:0] seen [16];
        logic [W2-1:0] e2;

        repeat (3) @(negedge Aclk);
        chk("rst_req", req1, 0);
        chk("rst_data", data1, SEED1);
        chk("rst_busy", busy1, 0);
        chk("rst_ws", ws1, 0);
        chk("rst_err", err1, 0);
        chk("rst_data2", data2, SEED2);
        reset = 1'b0;
        @(negedge Aclk);

        en2 = 1'b1;
        for (int k = 0; k < N2; k++) begin
            n = 0;
            while (req2 !== 1'b1 && n < 200) begin
                @(negedge Aclk); n++;
            end
            chk("req2_rise", req2, 1);
            seen[k] = data2;
            n = 0;
            while (ws2 !== 16'(k + 1) && n < 200) begin
                @(negedge Aclk); n++;
            end
            chk("ws2", ws2, k + 1);
            if (k == N2 - 1) en2 = 1'b0;
        end
`ifdef CDC_SRC_LFSR_EN
        dup = 0;
        for (int i = 0; i < 15; i++) begin
            if (seen[i] == '0) dup++;
            for (int j = 0; j < i; j++)
                if (seen[i] == seen[j]) dup++;
        end
        chk("lfsr_distinct", dup, 0);
        chk("lfsr_wrap", seen[15], 1);
`else
        e2 = SEED2;
        for (int k = 0; k < N2; k++) begin
            chk("seq2", seen[k], e2);
            e2 = W2'((int'(e2) + 1) % 256);
        end
`endif
        repeat (20) @(negedge Aclk);
        chk("idle_req2", req2, 0);
        chk("final_ws2", ws2, N2);

        en1 = 1'b1;
        @(negedge Aclk);
        chk("req_lat", req1, 1);
        chk("busy_on", busy1, 1);
        xfer(3, 3, 1'b0);
        chk("first_ws", ws1, 1);

        for (int i = 0; i < 8; i++)
            xfer($urandom_range(0, 6), $urandom_range(0, 6), 1'b0);

        xfer($urandom_range(0, 5), $urandom_range(0, 5), 1'b1);
        hi = 0;
        repeat (50) begin
            @(negedge Aclk);
            if (req1 === 1'b1) hi++;
        end
        chk("no_new_req", hi, 0);
        chk("ws_after_drop", ws1, exp_cnt);
        chk("stable_a", viol, 0);

        en1 = 1'b1;
        wait_req(1'b1, "t6_req");
        ack1 = 1'b1;
        wait_req(1'b0, "t6_drop");
        en1 = 1'b0;
        reset = 1'b1;
        @(negedge Aclk);
        chk("t6_req", req1, 0);
        chk("t6_data", data1, SEED1);
        chk("t6_ws", ws1, 0);
        chk("t6_busy", busy1, 0);
        ack1 = 1'b0;
        exp_word = SEED1;
        exp_cnt = 0;
        @(negedge Aclk);
        reset = 1'b0;
        repeat (5) @(negedge Aclk);
        chk("t6_idle", busy1, 0);

        en1 = 1'b1;
        wait_req(1'b1, "to_req");
        hi = 0;
        n = 0;
        while (req1 === 1'b1 && n < 600) begin
            hi++;
            @(negedge Aclk); n++;
        end
        chk("to_len", hi, TO1);
        chk("to_err", err1, 1);
        chk("to_busy", busy1, 1);
        repeat (4) begin
            en1 = ~en1;
            repeat (3) @(negedge Aclk);
        end
        chk("to_sticky", err1, 1);
        chk("to_req_low", req1, 0);
        chk("to_ws", ws1, 0);
        chk("stable_b", viol, 0);
        reset = 1'b1;
        @(negedge Aclk);
        chk("to_clr", err1, 0);
        chk("to_busy_clr", busy1, 0);
        reset = 1'b0;
        en1 = 1'b0;
        repeat (3) @(negedge Aclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cdc_word_source
